// File: rtl/flappy_core.sv
// Game engine for the LED-matrix flappy game: bird, scrolling pipes, collision,
// BCD score and the IDLE/PLAY/DEAD state, all advanced by a one-clk tick strobe.
module flappy_core #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int BIRD_COL     = 6,
  parameter int GAP          = 3,
  parameter int SPACING      = 4,
  parameter int FALL_DIV     = 4,
  parameter int SCROLL_DIV   = 8,
  parameter int SCORE_DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        flap,
  output logic [ROWS*COLS-1:0]        red_array,
  output logic [ROWS*COLS-1:0]        green_array,
  output logic [$clog2(ROWS)-1:0]     bird_row,
  output logic [1:0]                  state,
  output logic [4*SCORE_DIGITS-1:0]   score_bcd,
  output logic                        game_over
);
  localparam int RW = $clog2(ROWS);
  localparam int FW = (FALL_DIV   > 1) ? $clog2(FALL_DIV)   : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int PW = (SPACING    > 1) ? $clog2(SPACING)    : 1;
  localparam int NG = ROWS - GAP + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;

  state_t                    st, st_n;
  logic [RW-1:0]             row_n;
  logic [FW-1:0]             fall_cnt, fall_n;
  logic [SW-1:0]             scroll_cnt, scroll_n;
  logic [PW-1:0]             space_cnt, space_n;
  logic [ROWS*COLS-1:0]      green_n, green_scr;
  logic [COLS-1:0]           pflag, flag_n;
  logic [4*SCORE_DIGITS-1:0] score_n, score_inc;
  logic [15:0]               lfsr;
  logic                      flap_q, flap_pend, flap_ev;
  logic                      fall_step, scroll_step, hit, inc_carry;
  logic [7:0]                gap_lo;
  logic [ROWS-1:0]           pipe_col, bird_cur, bird_scr;

  assign state     = st;
  assign game_over = (st == DEAD);
  // a rise on the same clk as the tick still counts for that tick
  assign flap_ev   = flap_pend | (flap & ~flap_q);
  assign gap_lo    = lfsr[7:0] % 8'(NG);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign pipe_col[r]        = (space_cnt == '0) &&
                                !((8'(r) >= gap_lo) && (8'(r) < gap_lo + 8'(GAP)));
    assign green_scr[r*COLS]  = pipe_col[r];
    for (genvar c = 1; c < COLS; c++) begin : g_shift
      assign green_scr[r*COLS+c] = green_array[r*COLS+c-1];
    end
    assign bird_cur[r] = green_array[r*COLS+BIRD_COL];
    assign bird_scr[r] = green_scr[r*COLS+BIRD_COL];
    for (genvar c = 0; c < COLS; c++) begin : g_red
      assign red_array[r*COLS+c] = (c == BIRD_COL) && (bird_row == RW'(r));
    end
  end

  // BCD increment with ripple carry, holding at all-nines
  always_comb begin
    score_inc = score_bcd;
    inc_carry = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (inc_carry) begin
        if (score_bcd[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
    if (inc_carry) score_inc = score_bcd;
  end

  always_comb begin
    st_n        = st;
    row_n       = bird_row;
    fall_n      = fall_cnt;
    scroll_n    = scroll_cnt;
    space_n     = space_cnt;
    green_n     = green_array;
    flag_n      = pflag;
    score_n     = score_bcd;
    fall_step   = 1'b0;
    scroll_step = 1'b0;
    hit         = 1'b0;
    if (tick) begin
      case (st)
        IDLE: if (flap_ev) begin
          score_n = '0;
          row_n   = bird_row + 1'b1;
          st_n    = PLAY;
        end
        PLAY: begin
          if (flap_ev) begin
            if (bird_row != RW'(ROWS-1)) row_n = bird_row + 1'b1;
            fall_n = '0;
          end else if (fall_cnt == FW'(FALL_DIV-1)) begin
            fall_n    = '0;
            fall_step = 1'b1;
            if (bird_row != '0) row_n = bird_row - 1'b1;
          end else begin
            fall_n = fall_cnt + 1'b1;
          end
          if (scroll_cnt == SW'(SCROLL_DIV-1)) begin
            scroll_step = 1'b1;
            scroll_n    = '0;
            green_n     = green_scr;
            flag_n      = (pflag << 1) | COLS'(space_cnt == '0);
            space_n     = (space_cnt == PW'(SPACING-1)) ? '0 : space_cnt + 1'b1;
          end else begin
            scroll_n = scroll_cnt + 1'b1;
          end
          // collision looks at the board as it will be after this tick
          hit = (fall_step && (bird_row == '0)) ||
                (scroll_step ? bird_scr[row_n] : bird_cur[row_n]);
          if (hit)                              st_n    = DEAD;
          else if (scroll_step && pflag[BIRD_COL]) score_n = score_inc;
        end
        DEAD: if (flap_ev) begin
          st_n     = IDLE;
          green_n  = '0;
          flag_n   = '0;
          row_n    = RW'(ROWS/2);
          fall_n   = '0;
          scroll_n = '0;
          space_n  = '0;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bird_row    <= RW'(ROWS/2);
      fall_cnt    <= '0;
      scroll_cnt  <= '0;
      space_cnt   <= '0;
      green_array <= '0;
      pflag       <= '0;
      score_bcd   <= '0;
      lfsr        <= 16'hACE1;
      flap_q      <= 1'b0;
      flap_pend   <= 1'b0;
    end else begin
      bird_row    <= row_n;
      fall_cnt    <= fall_n;
      scroll_cnt  <= scroll_n;
      space_cnt   <= space_n;
      green_array <= green_n;
      pflag       <= flag_n;
      score_bcd   <= score_n;
      lfsr        <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      flap_q      <= flap;
      if (tick)                flap_pend <= 1'b0;
      else if (flap & ~flap_q) flap_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_flappy_core.sv
// Bench for flappy_core: a behavioural game model predicts each tick's outcome into a
// scoreboard; a second instance with one score digit covers score saturation.
module tb_flappy_core;
  localparam int ROWS = 8, COLS = 8, BIRD_COL = 6, GAP = 3;
  localparam int SPACING = 4, FALL_DIV = 4, SCROLL_DIV = 8;

  logic        clk = 1'b0, reset = 1'b1, tick = 1'b0, flap = 1'b0;
  logic [63:0] red, green, red2, green2;
  logic [2:0]  row, row2;
  logic [1:0]  st, st2;
  logic [11:0] score;
  logic [3:0]  score2;
  logic        go, go2;

  flappy_core #(.ROWS(ROWS), .COLS(COLS), .BIRD_COL(BIRD_COL), .GAP(GAP), .SPACING(SPACING),
                .FALL_DIV(FALL_DIV), .SCROLL_DIV(SCROLL_DIV), .SCORE_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .flap(flap), .red_array(red), .green_array(green),
    .bird_row(row), .state(st), .score_bcd(score), .game_over(go));

  flappy_core #(.ROWS(ROWS), .COLS(COLS), .BIRD_COL(BIRD_COL), .GAP(GAP), .SPACING(SPACING),
                .FALL_DIV(FALL_DIV), .SCROLL_DIV(SCROLL_DIV), .SCORE_DIGITS(1)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .flap(flap), .red_array(red2), .green_array(green2),
    .bird_row(row2), .state(st2), .score_bcd(score2), .game_over(go2));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // game model
  int        m_state, m_row, m_fall, m_scroll, m_space, m_score;
  bit [63:0] m_green;
  bit [7:0]  m_flag;
  bit [15:0] m_lfsr;
  bit        m_fq, m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_lfsr <= 16'hACE1; m_fq <= 1'b0; m_pend <= 1'b0;
    end else begin
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      m_fq   <= flap;
      if (tick)               m_pend <= 1'b0;
      else if (flap && !m_fq) m_pend <= 1'b1;
    end
  end

  typedef struct { int st; int row; bit [63:0] green; int score; } exp_t;
  exp_t sb[$];

  function automatic bit [11:0] bcd3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic push_exp();
    exp_t e;
    e.st = m_state; e.row = m_row; e.green = m_green; e.score = m_score;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    chk("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("state", st, e.st);
    chk("bird_row", row, e.row);
    chk("green", green, e.green);
    chk("red", red, 64'd1 << (e.row * COLS + BIRD_COL));
    chk("score", score, bcd3(e.score));
    chk("game_over", go, e.st == 2);
    chk("state2", st2, e.st);
    chk("row2", row2, e.row);
    chk("green2", green2 ^ red2, e.green ^ (64'd1 << (e.row * COLS + BIRD_COL)));
    chk("score2", score2, (e.score > 9) ? 9 : e.score);
  endtask

  task automatic model_tick(input bit ev);
    int g;
    bit fell, ground, scr, leaving;
    g = int'(m_lfsr[7:0]) % (ROWS - GAP + 1);
    case (m_state)
      0: if (ev) begin m_score = 0; m_row++; m_state = 1; end
      1: begin
        fell = 0;
        if (ev) begin
          if (m_row < ROWS - 1) m_row++;
          m_fall = 0;
        end else if (m_fall == FALL_DIV - 1) begin
          m_fall = 0; fell = 1;
        end else m_fall++;
        ground = fell && (m_row == 0);
        if (fell && m_row > 0) m_row--;
        scr     = (m_scroll == SCROLL_DIV - 1);
        leaving = m_flag[BIRD_COL];
        if (scr) begin
          m_scroll = 0;
          for (int c = COLS - 1; c > 0; c--)
            for (int r = 0; r < ROWS; r++) m_green[r*COLS+c] = m_green[r*COLS+c-1];
          for (int r = 0; r < ROWS; r++)
            m_green[r*COLS] = (m_space == 0) && !(r >= g && r < g + GAP);
          m_flag  = {m_flag[COLS-2:0], m_space == 0};
          m_space = (m_space + 1) % SPACING;
        end else m_scroll++;
        if (ground || m_green[m_row*COLS+BIRD_COL]) m_state = 2;
        else if (scr && leaving) m_score = (m_score < 999) ? m_score + 1 : 999;
      end
      default: if (ev) begin
        m_state = 0; m_green = '0; m_flag = '0; m_row = ROWS / 2;
        m_fall = 0; m_scroll = 0; m_space = 0;
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; flap = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_state = 0; m_row = ROWS / 2; m_fall = 0; m_scroll = 0; m_space = 0;
    m_green = '0; m_flag = '0; m_score = 0;
    sb.delete();
    push_exp();
    pop_cmp();
  endtask

  task automatic do_tick(input bit fl);
    bit ev;
    flap = fl; tick = 1'b1;
    ev = m_pend | (fl & ~m_fq);
    model_tick(ev);
    push_exp();
    @(posedge clk); @(negedge clk);
    tick = 1'b0;
    pop_cmp();
  endtask

  task automatic pulse();
    flap = 1'b0; @(negedge clk);
    flap = 1'b1; @(negedge clk);
  endtask

  function automatic int next_gap();
    for (int c = BIRD_COL; c >= 0; c--)
      if (m_flag[c])
        for (int r = 0; r < ROWS; r++) if (!m_green[r*COLS+c]) return r;
    return -1;
  endfunction

  initial begin
    int n, r0, zeros, g, tgt;
    @(negedge clk);
    do_reset();
    chk("rst_row", row, 4);
    chk("rst_red", red, 64'd1 << (4 * 8 + 6));
    chk("rst_green", green, 0);
    for (int i = 0; i < 8; i++) do_tick(0);
    chk("idle_state", st, 0);

    pulse(); do_tick(0);
    chk("start_state", st, 1);
    chk("start_row", row, 5);
    for (int i = 0; i < 4; i++) do_tick(0);
    chk("fall_row", row, 4);
    for (int i = 0; i < 8; i++) do_tick(0);
    zeros = 0;
    for (int r = 0; r < ROWS; r++) if (!green[r*COLS]) zeros++;
    chk("pipe_gap_rows", zeros, GAP);

    r0 = m_row;
    for (int i = 0; i < 3; i++) do_tick(1);
    chk("held_flap_row", row, r0 + 1);
    n = 0;
    while (m_row < ROWS - 1 && n < 10) begin pulse(); do_tick(0); n++; end
    pulse(); do_tick(0);
    chk("top_sat_row", row, 7);

    n = 0;
    while (m_state == 1 && n < 100) begin do_tick(0); n++; end
    chk("ground_state", st, 2);
    chk("ground_row", row, 0);
    chk("ground_go", go, 1);
    for (int i = 0; i < 3; i++) do_tick(0);

    pulse(); do_tick(0);
    chk("dead_to_idle", st, 0);
    chk("idle_board", green, 0);
    pulse(); do_tick(0);
    chk("replay_score", score, 0);

    // steer through gaps to cross 009 -> 010 and saturate the one-digit copy
    n = 0;
    while (m_score < 10 && m_state == 1 && n < 1500) begin
      g = next_gap();
      tgt = (g < 0) ? ROWS / 2 : g + 1;
      if (m_row < tgt) pulse();
      do_tick(0);
      n++;
    end
    chk("score_010", score, 12'h010);
    chk("score2_sat", score2, 4'h9);

    // climb out of the gap so the next pipe is hit
    n = 0;
    while (m_state == 1 && n < 300) begin
      g = next_gap();
      if (g >= 0 && g < ROWS - GAP && m_row < ROWS - 1) pulse();
      do_tick(0);
      n++;
    end
    chk("crash_state", st, 2);
    pulse(); do_tick(0);
    chk("crash_idle_board", green, 0);
    pulse(); do_tick(0);
    chk("crash_replay_score", score, 0);
    for (int i = 0; i < 10; i++) do_tick(0);

    do_reset();
    chk("midplay_rst_state", st, 0);
    chk("midplay_rst_green", green, 0);
    chk("midplay_rst_row", row, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
